// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared display timing constants, coordinate type and helpers
//
// Holds the 640x480@60 default timing, the derived totals and sync windows,
// and the coordinate width shared with the icon and world-map lookups.
package vga_timing_pkg;

    // Coordinate width used by every module that consumes pixel_column/pixel_row.
    localparam int CNT_W     = 10;
    localparam int CNT_LIMIT = 1 << CNT_W;

    typedef logic [CNT_W-1:0] coord_t;

    // 640x480@60 on a 25 MHz pixel clock.
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    // Sync windows: start is the first asserted count, end is one past the last.
    localparam int DEF_HS_START = DEF_H_ACTIVE + DEF_H_FP;
    localparam int DEF_HS_END   = DEF_HS_START + DEF_H_SYNC;
    localparam int DEF_VS_START = DEF_V_ACTIVE + DEF_V_FP;
    localparam int DEF_VS_END   = DEF_VS_START + DEF_V_SYNC;

    // Inclusive window test; bounds are given as first/last so a window that
    // ends exactly at the counter limit never needs an 11-bit constant.
    function automatic logic in_window(input coord_t v, input coord_t first, input coord_t last);
        return (v >= first) && (v <= last);
    endfunction

endpackage

// File: rtl/vga_timing_gen_sync_delay.sv
// rtl/vga_timing_gen_sync_delay.sv - fixed-depth shift register with a reset value
//
// Delays one sync level by DEPTH clocks. Every stage resets to RST_VAL so no
// stale pulse can emerge after a reset. DEPTH = 0 is a plain wire.
//
// Ports:
//   clock - pixel clock
//   rst   - synchronous, active-high reset
//   din   - level to delay
//   dout  - din delayed DEPTH clocks
module sync_delay #(
    parameter int   DEPTH   = 1,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clock,
    input  logic rst,
    input  logic din,
    output logic dout
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic unused_clk_rst;
            assign unused_clk_rst = clock ^ rst;
            assign dout = din;
        end else begin : g_shift
            logic [DEPTH-1:0] shift_q;
            logic [DEPTH-1:0] shift_d;

            always_comb begin
                shift_d[0] = din;
                for (int i = 1; i < DEPTH; i++) begin
                    shift_d[i] = shift_q[i-1];
                end
                if (rst) begin
                    shift_d = {DEPTH{RST_VAL}};
                end
            end

            always_ff @(posedge clock) begin
                shift_q <= shift_d;
            end

            assign dout = shift_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA display timing generator (counters, video_on, syncs)
//
// Produces the pixel coordinates and active-area flag consumed by the
// world-map/icon lookups and the colorizer, plus sync outputs delayed to
// line up with the colorizer's registered colour.
//
// Ports:
//   clock        - pixel clock (25 MHz for the default timing)
//   rst          - synchronous, active-high reset
//   pixel_column - horizontal count 0..H_TOTAL-1
//   pixel_row    - vertical count 0..V_TOTAL-1
//   video_on     - current coordinate lies in the active area
//   horiz_sync   - horizontal sync, SYNC_DLY clocks behind the counters
//   vert_sync    - vertical sync, SYNC_DLY clocks behind the counters
//   line_start   - one-clock pulse while pixel_column == 0
//   frame_start  - one-clock pulse while pixel_column == 0 and pixel_row == 0
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic SYNC_POL = 1'b0,
    parameter int   SYNC_DLY = 1
) (
    input  logic             clock,
    input  logic             rst,
    output logic [CNT_W-1:0] pixel_column,
    output logic [CNT_W-1:0] pixel_row,
    output logic             video_on,
    output logic             horiz_sync,
    output logic             vert_sync,
    output logic             line_start,
    output logic             frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
    localparam coord_t H_ACT_C  = coord_t'(H_ACTIVE);
    localparam coord_t V_ACT_C  = coord_t'(V_ACTIVE);
    localparam coord_t HS_FIRST = coord_t'(H_ACTIVE + H_FP);
    localparam coord_t HS_LAST  = coord_t'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam coord_t VS_FIRST = coord_t'(V_ACTIVE + V_FP);
    localparam coord_t VS_LAST  = coord_t'(V_ACTIVE + V_FP + V_SYNC - 1);

    localparam logic SYNC_IDLE = ~SYNC_POL;

    generate
        if (H_TOTAL > CNT_LIMIT) begin : g_bad_h_total
            $error("vga_timing_gen: H_TOTAL exceeds the coordinate range");
        end
        if (V_TOTAL > CNT_LIMIT) begin : g_bad_v_total
            $error("vga_timing_gen: V_TOTAL exceeds the coordinate range");
        end
        if (SYNC_DLY < 0 || SYNC_DLY > 4) begin : g_bad_sync_dly
            $error("vga_timing_gen: SYNC_DLY must be 0..4");
        end
    endgenerate

    coord_t col_q, col_d;
    coord_t row_q, row_d;
    logic   video_on_q, video_on_d;
    logic   line_start_q, line_start_d;
    logic   frame_start_q, frame_start_d;
    // Sync levels already in output polarity, aligned with the counters.
    logic   hs_lvl_q, hs_lvl_d;
    logic   vs_lvl_q, vs_lvl_d;
    logic   col_wrap;

    // Everything registered is decoded from the next counter values so the
    // flags land on the same edge as the coordinates they describe.
    always_comb begin
        col_wrap = (col_q == H_LAST);
        col_d    = col_wrap ? '0 : col_q + 1'b1;
        row_d    = row_q;
        if (col_wrap) begin
            row_d = (row_q == V_LAST) ? '0 : row_q + 1'b1;
        end

        video_on_d    = (col_d < H_ACT_C) && (row_d < V_ACT_C);
        line_start_d  = (col_d == '0);
        frame_start_d = (col_d == '0) && (row_d == '0);
        hs_lvl_d      = in_window(col_d, HS_FIRST, HS_LAST) ? SYNC_POL : SYNC_IDLE;
        vs_lvl_d      = in_window(row_d, VS_FIRST, VS_LAST) ? SYNC_POL : SYNC_IDLE;

        // Reset parks the counters on the last count so the first free-running
        // edge lands on (0,0) with frame_start.
        if (rst) begin
            col_d         = H_LAST;
            row_d         = V_LAST;
            video_on_d    = 1'b0;
            line_start_d  = 1'b0;
            frame_start_d = 1'b0;
            hs_lvl_d      = SYNC_IDLE;
            vs_lvl_d      = SYNC_IDLE;
        end
    end

    always_ff @(posedge clock) begin
        col_q         <= col_d;
        row_q         <= row_d;
        video_on_q    <= video_on_d;
        line_start_q  <= line_start_d;
        frame_start_q <= frame_start_d;
        hs_lvl_q      <= hs_lvl_d;
        vs_lvl_q      <= vs_lvl_d;
    end

    // Extra delay matches the colorizer's registered colour output.
    sync_delay #(
        .DEPTH   (SYNC_DLY),
        .RST_VAL (SYNC_IDLE)
    ) u_hs_delay (
        .clock (clock),
        .rst   (rst),
        .din   (hs_lvl_q),
        .dout  (horiz_sync)
    );

    sync_delay #(
        .DEPTH   (SYNC_DLY),
        .RST_VAL (SYNC_IDLE)
    ) u_vs_delay (
        .clock (clock),
        .rst   (rst),
        .din   (vs_lvl_q),
        .dout  (vert_sync)
    );

    assign pixel_column = col_q;
    assign pixel_row    = row_q;
    assign video_on     = video_on_q;
    assign line_start   = line_start_q;
    assign frame_start  = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed self-checking bench for vga_timing_gen
module tb_vga_timing_gen;

    logic       clock = 1'b0;
    logic [2:0] rst_v = 3'b111;
    int         checks = 0;
    int         failures = 0;

    always #20 clock = ~clock;

    logic [9:0] a_col, a_row, b_col, b_row, c_col, c_row;
    logic       a_von, a_hs, a_vs, a_ls, a_fs;
    logic       b_von, b_hs, b_vs, b_ls, b_fs;
    logic       c_von, c_hs, c_vs, c_ls, c_fs;

    // Default 640x480 timing, active-low syncs delayed 1 clock.
    vga_timing_gen u_a (
        .clock(clock), .rst(rst_v[0]), .pixel_column(a_col), .pixel_row(a_row),
        .video_on(a_von), .horiz_sync(a_hs), .vert_sync(a_vs),
        .line_start(a_ls), .frame_start(a_fs)
    );

    // Default timing, active-high syncs, no delay.
    vga_timing_gen #(.SYNC_POL(1'b1), .SYNC_DLY(0)) u_b (
        .clock(clock), .rst(rst_v[1]), .pixel_column(b_col), .pixel_row(b_row),
        .video_on(b_von), .horiz_sync(b_hs), .vert_sync(b_vs),
        .line_start(b_ls), .frame_start(b_fs)
    );

    // Miniature 16x8 frame so full frames fit in a short run; delay 2.
    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_POL(1'b0), .SYNC_DLY(2)
    ) u_c (
        .clock(clock), .rst(rst_v[2]), .pixel_column(c_col), .pixel_row(c_row),
        .video_on(c_von), .horiz_sync(c_hs), .vert_sync(c_vs),
        .line_start(c_ls), .frame_start(c_fs)
    );

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    // Leaves instance k showing (0,0).
    task automatic release_rst(input int k);
        rst_v[k] = 1'b1;
        repeat (2) tick();
        rst_v[k] = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst_v[0] = 1'b1;
        repeat (5) tick();
        checks++;
        if (a_col !== 10'd799 || a_row !== 10'd524) begin
            failures++;
            $display("FAIL reset_counters col=%0d row=%0d expected col=799 row=524", a_col, a_row);
        end
        checks++;
        if ({a_von, a_ls, a_fs} !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags von/ls/fs=%b expected 000", {a_von, a_ls, a_fs});
        end
        checks++;
        if ({a_hs, a_vs} !== 2'b11) begin
            failures++;
            $display("FAIL reset_syncs hs/vs=%b expected 11", {a_hs, a_vs});
        end
        rst_v[0] = 1'b0;
        tick();
        checks++;
        if (a_col !== 10'd0 || a_row !== 10'd0) begin
            failures++;
            $display("FAIL release_counters col=%0d row=%0d expected col=0 row=0", a_col, a_row);
        end
        checks++;
        if ({a_von, a_ls, a_fs} !== 3'b111) begin
            failures++;
            $display("FAIL release_flags von/ls/fs=%b expected 111", {a_von, a_ls, a_fs});
        end
        checks++;
        if ({a_hs, a_vs} !== 2'b11) begin
            failures++;
            $display("FAIL release_syncs hs/vs=%b expected 11", {a_hs, a_vs});
        end
    endtask

    task automatic test_active_edge();
        repeat (639) tick();
        checks++;
        if (a_col !== 10'd639 || a_von !== 1'b1) begin
            failures++;
            $display("FAIL active_col639 col=%0d von=%b expected col=639 von=1", a_col, a_von);
        end
        tick();
        checks++;
        if (a_col !== 10'd640 || a_von !== 1'b0) begin
            failures++;
            $display("FAIL active_col640 col=%0d von=%b expected col=640 von=0", a_col, a_von);
        end
    endtask

    task automatic test_hsync_line();
        int first_low, rise, low_cnt, ls_cnt, col_bad;
        first_low = -1; rise = -1; low_cnt = 0; ls_cnt = 0; col_bad = 0;
        release_rst(0);
        for (int i = 0; i < 800; i++) begin
            if (a_col !== 10'(i) || a_row !== 10'd0) col_bad++;
            if (a_ls === 1'b1) ls_cnt++;
            if (a_hs === 1'b0) begin
                low_cnt++;
                if (first_low < 0) first_low = i;
            end else if (first_low >= 0 && rise < 0) begin
                rise = i;
            end
            tick();
        end
        checks++;
        if (col_bad != 0) begin
            failures++;
            $display("FAIL line_count_seq bad_cycles=%0d expected 0", col_bad);
        end
        checks++;
        if (first_low != 657) begin
            failures++;
            $display("FAIL hs_fall_col got=%0d expected 657", first_low);
        end
        checks++;
        if (rise != 753) begin
            failures++;
            $display("FAIL hs_rise_col got=%0d expected 753", rise);
        end
        checks++;
        if (low_cnt != 96) begin
            failures++;
            $display("FAIL hs_low_width got=%0d expected 96", low_cnt);
        end
        checks++;
        if (ls_cnt != 1) begin
            failures++;
            $display("FAIL line_start_per_line got=%0d expected 1", ls_cnt);
        end
        checks++;
        if (a_col !== 10'd0 || a_row !== 10'd1 || a_ls !== 1'b1 || a_fs !== 1'b0) begin
            failures++;
            $display("FAIL line_wrap col=%0d row=%0d ls=%b fs=%b expected col=0 row=1 ls=1 fs=0",
                     a_col, a_row, a_ls, a_fs);
        end
    endtask

    task automatic test_mid_reset();
        repeat (300) tick();
        checks++;
        if (a_col !== 10'd300 || a_row !== 10'd1) begin
            failures++;
            $display("FAIL midrst_pre col=%0d row=%0d expected col=300 row=1", a_col, a_row);
        end
        rst_v[0] = 1'b1;
        tick();
        rst_v[0] = 1'b0;
        checks++;
        if (a_col !== 10'd799 || a_row !== 10'd524 || {a_von, a_ls, a_fs} !== 3'b000) begin
            failures++;
            $display("FAIL midrst_values col=%0d row=%0d flags=%b expected col=799 row=524 flags=000",
                     a_col, a_row, {a_von, a_ls, a_fs});
        end
        tick();
        checks++;
        if (a_col !== 10'd0 || a_row !== 10'd0 || a_fs !== 1'b1 || a_von !== 1'b1) begin
            failures++;
            $display("FAIL midrst_restart col=%0d row=%0d fs=%b von=%b expected col=0 row=0 fs=1 von=1",
                     a_col, a_row, a_fs, a_von);
        end
        repeat (700) tick();
        checks++;
        if (a_hs !== 1'b0) begin
            failures++;
            $display("FAIL hs_low_before_rst hs=%b expected 0", a_hs);
        end
        rst_v[0] = 1'b1;
        tick();
        rst_v[0] = 1'b0;
        checks++;
        if (a_hs !== 1'b1 || a_col !== 10'd799) begin
            failures++;
            $display("FAIL hs_cut_by_rst hs=%b col=%0d expected hs=1 col=799", a_hs, a_col);
        end
        tick();
    endtask

    task automatic test_alt_params();
        int bad, first_high, high_cnt, vs_bad;
        logic exp_hs;
        bad = 0; first_high = -1; high_cnt = 0; vs_bad = 0;
        release_rst(1);
        for (int i = 0; i < 800; i++) begin
            exp_hs = (i >= 656 && i <= 751);
            if (b_hs !== exp_hs) bad++;
            if (b_hs === 1'b1) begin
                high_cnt++;
                if (first_high < 0) first_high = i;
            end
            if (b_vs !== 1'b0) vs_bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL alt_hs_window bad_cycles=%0d expected 0", bad);
        end
        checks++;
        if (first_high != 656) begin
            failures++;
            $display("FAIL alt_hs_first got=%0d expected 656", first_high);
        end
        checks++;
        if (high_cnt != 96) begin
            failures++;
            $display("FAIL alt_hs_width got=%0d expected 96", high_cnt);
        end
        checks++;
        if (vs_bad != 0) begin
            failures++;
            $display("FAIL alt_vs_idle bad_cycles=%0d expected 0", vs_bad);
        end
    endtask

    task automatic test_frame_small();
        int cnt_bad, von_bad, ls_bad, fs_bad, fs_cnt, hs_bad, vs_bad, vs_first, vs_low;
        int c, r, pc, pr;
        logic exp_von, exp_hs, exp_vs, von_r3, von_r4;
        cnt_bad = 0; von_bad = 0; ls_bad = 0; fs_bad = 0; fs_cnt = 0;
        hs_bad = 0; vs_bad = 0; vs_first = -1; vs_low = 0;
        von_r3 = 1'b0; von_r4 = 1'b1;
        release_rst(2);
        for (int i = 0; i < 260; i++) begin
            c = i % 16;
            r = (i / 16) % 8;
            if (c_col !== 10'(c) || c_row !== 10'(r)) cnt_bad++;
            exp_von = (c < 8) && (r < 4);
            if (c_von !== exp_von) von_bad++;
            if (c_ls !== (c == 0)) ls_bad++;
            if (c_fs !== (c == 0 && r == 0)) fs_bad++;
            if (c_fs === 1'b1) fs_cnt++;
            exp_hs = 1'b1;
            exp_vs = 1'b1;
            if (i >= 2) begin
                pc = (i - 2) % 16;
                pr = ((i - 2) / 16) % 8;
                exp_hs = !(pc >= 10 && pc <= 12);
                exp_vs = !(pr >= 5 && pr <= 6);
            end
            if (c_hs !== exp_hs) hs_bad++;
            if (c_vs !== exp_vs) vs_bad++;
            if (c_vs === 1'b0 && i < 128) begin
                vs_low++;
                if (vs_first < 0) vs_first = i;
            end
            if (i == 48) von_r3 = c_von;
            if (i == 64) von_r4 = c_von;
            tick();
        end
        checks++;
        if (cnt_bad != 0) begin failures++; $display("FAIL small_counters bad_cycles=%0d expected 0", cnt_bad); end
        checks++;
        if (von_bad != 0) begin failures++; $display("FAIL small_video_on bad_cycles=%0d expected 0", von_bad); end
        checks++;
        if (ls_bad != 0) begin failures++; $display("FAIL small_line_start bad_cycles=%0d expected 0", ls_bad); end
        checks++;
        if (fs_bad != 0) begin failures++; $display("FAIL small_frame_start bad_cycles=%0d expected 0", fs_bad); end
        checks++;
        if (fs_cnt != 3) begin failures++; $display("FAIL small_frame_count got=%0d expected 3", fs_cnt); end
        checks++;
        if (hs_bad != 0) begin failures++; $display("FAIL small_hs_delay2 bad_cycles=%0d expected 0", hs_bad); end
        checks++;
        if (vs_bad != 0) begin failures++; $display("FAIL small_vs_delay2 bad_cycles=%0d expected 0", vs_bad); end
        checks++;
        if (vs_first != 82) begin failures++; $display("FAIL small_vs_fall got=%0d expected 82", vs_first); end
        checks++;
        if (vs_low != 32) begin failures++; $display("FAIL small_vs_width got=%0d expected 32", vs_low); end
        checks++;
        if (von_r3 !== 1'b1) begin failures++; $display("FAIL small_last_active_row von=%b expected 1", von_r3); end
        checks++;
        if (von_r4 !== 1'b0) begin failures++; $display("FAIL small_first_blank_row von=%b expected 0", von_r4); end
    endtask

    initial begin
        @(negedge clock);
        test_reset();
        test_active_edge();
        test_hsync_line();
        test_mid_reset();
        test_alt_params();
        test_frame_small();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Display timing generator: the producer end of the pixel/video interface that the colorizer consumes.
- Generates pixel_column/pixel_row for the world-map and icon lookups, video_on for the colorizer, and horiz_sync/vert_sync for the VGA connector.
- Sync outputs are delayed to line up with the colorizer's registered (1-cycle) colour output.
- Default timing is 640x480@60 on the 25 MHz pixel clock.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, asserted sync level (0 = active-low)
- SYNC_DLY, 1, extra clocks of sync delay relative to counters (0..4)

Ports:
- clock  in  1  25 MHz pixel clock
- rst  in  1  synchronous, active-high reset
- pixel_column  out  10  current horizontal count 0..H_TOTAL-1
- pixel_row  out  10  current vertical count 0..V_TOTAL-1
- video_on  out  1  1 = (pixel_column, pixel_row) is in the active area
- horiz_sync  out  1  horizontal sync, delayed SYNC_DLY clocks
- vert_sync  out  1  vertical sync, delayed SYNC_DLY clocks
- line_start  out  1  1-clock pulse when pixel_column == 0
- frame_start  out  1  1-clock pulse when pixel_column == 0 and pixel_row == 0

Behaviour:
- Derived totals: H_TOTAL = sum of the H_* parameters (800); V_TOTAL = sum of the V_* parameters (525). Both must be <= 1024; a larger value is an elaboration error.
- Reset values:
  - pixel_column = H_TOTAL-1, pixel_row = V_TOTAL-1
  - video_on = 0, line_start = 0, frame_start = 0
  - horiz_sync and vert_sync, and every stage of their delay line, at the inactive level ~SYNC_POL
- First edge after rst deasserts: counters wrap to (0,0); video_on = 1, line_start = 1, frame_start = 1.
- Counters, every clock:
  - pixel_column increments and wraps H_TOTAL-1 -> 0.
  - On that wrap, pixel_row increments and wraps V_TOTAL-1 -> 0.
  - No other wrap points; no stall input.
- video_on, line_start and frame_start are registered from the next-counter values, so they are cycle-aligned with the counter outputs (zero latency to the counters).
- video_on = (pixel_column < H_ACTIVE) and (pixel_row < V_ACTIVE).
- Raw sync terms, computed from the next-counter values and aligned with the counters:
  - hs_raw asserted for H_ACTIVE+H_FP <= col < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751.
  - vs_raw asserted for V_ACTIVE+V_FP <= row < V_ACTIVE+V_FP+V_SYNC, i.e. 490..491, for whole lines.
- Sync delay: horiz_sync/vert_sync equal hs_raw/vs_raw delayed SYNC_DLY clocks through a shift register. With SYNC_DLY = 0 they equal the raw terms. The asserted level is SYNC_POL.
- Mid-frame rst: takes effect on the next edge and returns all state to the reset values, delay line included. No partial sync pulse survives the reset beyond the cycle in which rst is sampled.
- Widths: counters are 10-bit unsigned; comparisons are unsigned against constants widened to 10 bits.

Decomposition:
- Shared package vga_timing_pkg holds:
  - the 640x480@60 default constants;
  - the derived H_TOTAL/V_TOTAL;
  - the sync-window start/end constants;
  - the 10-bit counter width, so the icon and world-map modules use the same coordinate width.
- One sub-module, sync_delay: a parameterised-depth shift register with a reset value, instantiated for each sync signal.

Test Plan:
- Reset release, default parameters:
  - rst held 5 clocks then dropped -> first edge gives col = 0, row = 0, video_on = 1, frame_start = 1; horiz_sync and vert_sync = 1 (inactive, active-low).
- Active-window edge, row 0:
  - col = 639 -> video_on = 1; col = 640 -> video_on = 0.
  - row = 479 active; row = 480 -> video_on = 0 for the whole line.
- Horizontal sync, row 0:
  - horiz_sync = 0 for exactly 96 consecutive clocks.
  - Falling edge occurs 1 clock after col = 656 (SYNC_DLY = 1); rises 1 clock after col = 752.
- Line/frame wrap:
  - col 799 -> 0 with row +1; line_start pulses every 800 clocks.
  - frame_start pulses every 420000 clocks; vert_sync = 0 for 1600 clocks starting 1 clock after (0,490).
- Mid-frame reset:
  - assert rst at (300,200) for 1 clock -> next edge shows reset values; the following edge shows (0,0), frame_start = 1.
  - Assert rst while horiz_sync is low -> horiz_sync goes high on the edge that samples rst.
- Alternate parameters: SYNC_DLY = 0, SYNC_POL = 1 -> horiz_sync = 1 in the same cycle col = 656, and exactly for cols 656..751.
